interfaz_botones_alu_param: RTL

- Parametrised successor to the button/switch-to-ALU front end.
- Each of the 5 push buttons is synchronised and debounced, then turned into a single-cycle edge pulse.
- Operands A/B are latched from the switches and the ALU opcode is stepped forward/back with wrap-around.
- Operations are issued to the ALU through a valid/ready handshake; operands and opcode stay frozen while a request is outstanding.

---
 rtl/interfaz_botones_alu_param.sv | 104 ++++++++++
 1 files changed

// File: rtl/interfaz_botones_alu_param.sv
// Button/switch front end for an ALU: synchronise, debounce and edge-detect 5 buttons,
// latch operands/opcode, and issue operations over a valid/ready handshake.
module interfaz_botones_alu_param #(
  parameter int WIDTH           = 8,
  parameter int N_OPS           = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] num_a_in,
  input  logic [WIDTH-1:0] num_b_in,
  input  logic [4:0]       push,
  input  logic             alu_ready,
  output logic [WIDTH-1:0] num_a_out,
  output logic [WIDTH-1:0] num_b_out,
  output logic [3:0]       ALU_control,
  output logic             op_valid,
  output logic             busy
);

  localparam int              CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]      OP_LAST  = 4'(N_OPS - 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  logic [4:0]    sync1_q, sync2_q, level_q, level_prev_q, press;
  logic [CW-1:0] cnt_q [5];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q      <= push;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_q[i]   <= '0;
          level_q[i] <= ~level_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press = level_q & ~level_prev_q;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (press[0]) a_d = num_a_in;
        if (press[1]) b_d = num_b_in;
        if (press[2] && !press[3]) begin
          op_d = (op_q == OP_LAST) ? 4'd0 : op_q + 4'd1;
        end else if (press[3] && !press[2]) begin
          op_d = (op_q == 4'd0) ? OP_LAST : op_q - 4'd1;
        end
        if (press[4]) state_d = ISSUE;
      end
      ISSUE: begin
        if (alu_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  assign num_a_out   = a_q;
  assign num_b_out   = b_q;
  assign ALU_control = op_q;
  assign op_valid    = (state_q == ISSUE);
  assign busy        = (state_q == ISSUE);

endmodule
